// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the RV32E fetch stage.
// Holds the NOP encoding, the default reset PC, FSM encodings and the queue entry layout.
package instruction_fetch_pkg;

  localparam logic [31:0] I_NOP            = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [0:0] IF_FETCH = 1'b0;
  localparam logic [0:0] IF_HALT  = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// Two-entry {pc, instr} FIFO; head is a register, so reading it adds no combinational depth.
// Latency: a push is visible at the head on the next cycle. Backpressure: a full queue ignores push unless popped that cycle.
module instruction_fetch_queue
  import instruction_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  logic [63:0] push_dat_i,
  input  logic        pop_i,
  input  logic        flush_i,
  output logic [1:0]  count_o,
  output logic [63:0] head_o
);

  fetch_entry_t entry0_q, entry0_d;
  fetch_entry_t entry1_q, entry1_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;
  logic         push_ok;

  assign pop_ok  = pop_i && (count_q != 2'd0);
  assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

  // entry0 is always the head; entry1 only ever holds the second-oldest word
  always_comb begin
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    count_d  = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else if (push_ok && !pop_ok) begin
      if (count_q == 2'd0) entry0_d = push_dat_i;
      else                 entry1_d = push_dat_i;
      count_d = count_q + 2'd1;
    end else if (!push_ok && pop_ok) begin
      entry0_d = entry1_q;
      count_d  = count_q - 2'd1;
    end else if (push_ok && pop_ok) begin
      if (count_q == 2'd1) begin
        entry0_d = push_dat_i;
      end else begin
        entry0_d = entry1_q;
        entry1_d = push_dat_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '{pc: 32'h0, instr: I_NOP};
      entry1_q <= '{pc: 32'h0, instr: I_NOP};
      count_q  <= 2'd0;
    end else begin
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = entry0_q;

endmodule

// File: rtl/instruction_fetch.sv
// RV32E fetch stage: PC register, ROM addressing, 2-deep instruction queue, redirect and halt handling.
// Latency: ROM word reaches out_* one cycle after its address is driven. Backpressure: out_ready low fills the queue, then the PC stalls.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misaligned_err
);

  logic [0:0]   state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         err_q, err_d;
  logic [1:0]   count;
  logic [63:0]  head_raw;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         fetching;
  logic         redirect_act;
  logic         pop;
  logic         push;

  assign fetching     = (state_q == IF_FETCH);
  assign redirect_act = fetching && redirect_valid;
  assign out_valid    = fetching && (count != 2'd0);
  assign pop          = out_valid && out_ready;
  assign push         = fetching && !redirect_valid && ((count != 2'd2) || pop);
  assign push_entry   = '{pc: pc_q, instr: rom_data};

  // A redirect outranks push/pop; a misaligned target also parks the FSM in HALT
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    err_d   = err_q;
    if (redirect_act) begin
      if (is_aligned(redirect_target)) begin
        pc_d = redirect_target;
      end else begin
        state_d = IF_HALT;
        err_d   = 1'b1;
      end
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IF_FETCH;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  instruction_fetch_queue u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_dat_i (push_entry),
    .pop_i      (pop),
    .flush_i    (redirect_act),
    .count_o    (count),
    .head_o     (head_raw)
  );

  assign head           = head_raw;
  assign rom_addr       = pc_q;
  assign out_instr      = head.instr;
  assign out_pc         = head.pc;
  assign misaligned_err = err_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: fixed vector table, async-reset sequence, then random traffic vs a queue-based model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misaligned_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    if (a[31:5] == 27'd0) begin
      case (a[4:2])
        3'd0: return 32'hF0CA_D137;
        3'd1: return 32'hAFE1_0113;
        3'd2: return 32'h1234_5678;
        3'd3: return 32'h0BAD_F00D;
        3'd4: return 32'hDEAD_BEEF;
        3'd5: return 32'h0055_AA33;
        3'd6: return 32'hC001_D00D;
        default: return 32'h7777_0197;
      endcase
    end
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  instruction_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .misaligned_err  (misaligned_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of PCs waiting for decode, next fetch address, halt/error flags
  logic [31:0] m_q[$];
  logic [31:0] m_pc;
  logic        m_halt;
  logic        m_err;

  task automatic model_reset();
    m_q.delete();
    m_pc   = 32'h0;
    m_halt = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic model_step(input logic ready, input logic rv, input logic [31:0] rt);
    if (m_halt) return;
    if (rv) begin
      m_q.delete();
      if (rt % 4 != 0) begin
        m_halt = 1'b1;
        m_err  = 1'b1;
      end else begin
        m_pc = rt;
      end
    end else begin
      if (ready && m_q.size() > 0) void'(m_q.pop_front());
      if (m_q.size() < 2) begin
        m_q.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic model_check(input string tag);
    logic exp_v;
    exp_v = !m_halt && (m_q.size() > 0);
    chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, exp_v});
    if (exp_v) begin
      chk({tag, ".pc"}, out_pc, m_q[0]);
      chk({tag, ".instr"}, out_instr, rom_fn(m_q[0]));
    end
    chk({tag, ".addr"}, rom_addr, m_pc);
    chk({tag, ".err"}, {31'h0, misaligned_err}, {31'h0, m_err});
  endtask

  task automatic cycle(input logic ready, input logic rv, input logic [31:0] rt, input string tag);
    out_ready       = ready;
    redirect_valid  = rv;
    redirect_target = rt;
    @(posedge clk);
    #1;
    model_step(ready, rv, rt);
    model_check(tag);
  endtask

  typedef struct {
    logic        ready;
    logic        rv;
    logic [31:0] rt;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        eerr;
  } vec_t;

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h4,         1'b0};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8,         1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8,         1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8,         1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'h8,         1'b0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'hC,         1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h10,        1'b0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         32'h10,        1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h1C,        1'b0, 32'h0,         32'h1C,        1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h1C,        32'h20,        1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h20,        32'h24,        1'b0};
    vecs[11] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0,         32'hFFFF_FFF8, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'h0,         1'b0};
    vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'h4,         1'b0};
    vecs[15] = '{1'b1, 1'b1, 32'h6,         1'b0, 32'h0,         32'h4,         1'b1};
    vecs[16] = '{1'b1, 1'b1, 32'h40,        1'b0, 32'h0,         32'h4,         1'b1};
    vecs[17] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h4,         1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'h0, out_valid}, 32'h0);
    chk("rst.instr", out_instr, 32'h0000_0013);
    chk("rst.pc", out_pc, 32'h0);
    chk("rst.addr", rom_addr, 32'h0);
    chk("rst.err", {31'h0, misaligned_err}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      out_ready       = vecs[i].ready;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].rt;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.valid", i), {31'h0, out_valid}, {31'h0, vecs[i].ev});
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d.pc", i), out_pc, vecs[i].epc);
        chk($sformatf("vec%0d.instr", i), out_instr, rom_fn(vecs[i].epc));
      end
      chk($sformatf("vec%0d.addr", i), rom_addr, vecs[i].eaddr);
      chk($sformatf("vec%0d.err", i), {31'h0, misaligned_err}, {31'h0, vecs[i].eerr});
    end

    // Reset pulse between edges releases HALT
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    cycle(1'b0, 1'b0, 32'h0, "fill0");
    cycle(1'b0, 1'b0, 32'h0, "fill1");
    cycle(1'b0, 1'b0, 32'h0, "fill2");

    // Asynchronous reset with a full queue, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'h0, out_valid}, 32'h0);
    chk("arst.addr", rom_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0, 32'h0, "restart0");
    chk("restart.pc0", out_pc, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, "restart1");
    chk("restart.pc4", out_pc, 32'h4);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic        r;
      logic        rv;
      logic [31:0] rt;
      if (m_halt && $urandom_range(0, 9) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
      end
      r  = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) rt = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      else                           rt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) rt[1:0] = 2'($urandom_range(1, 3));
      cycle(r, rv, rt, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
